frect: RTL
==========

# frect

Filled-rectangle sequencer for the 2D graphics pipeline. It accepts two corner points and walks the rectangle row by row. For each row it drives a horizontal span engine and emits one pixel coordinate per enabled cycle. It sits between the drawing command decoder and the framebuffer write port, using the same start/oe/valid/busy/done handshake as the other shape generators.

## Interface
- CORDW, default 16: signed coordinate width (bits).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a rectangle; sampled only in IDLE.
- oe  in  1  output enable; low stalls pixel output.
- x0, y0  in  CORDW signed  corner 0.
- x1, y1  in  CORDW signed  corner 1.
- outline  in  1  draw the border only (present only with FRECT_OUTLINE_EN).
- x, y  out  CORDW signed  pixel position.
- valid  out  1  x/y valid this cycle.
- busy  out  1  rectangle in progress.
- done  out  1  one-cycle pulse on completion.

## Operation
- States:
  - IDLE: waiting for start.
  - SPAN_START: asserts span-engine start for the current row.
  - SPAN_DRAW: waits for the span-engine done pulse.
  - RIGHT_START: outline mode only; starts the right-edge pixel.
  - FIN: raises done.
- Coordinate latch on start in IDLE:
  - x_lo/x_hi = min/max(x0,x1).
  - row = min(y0,y1); y_end = max(y0,y1).
  - outline is latched at the same time.
  - Next state is SPAN_START, and busy rises the same cycle.
- SPAN_START: span engine started on x_lo..x_hi.
  - Outline interior row: span is x_lo..x_lo instead.
  - Next state SPAN_DRAW.
- SPAN_DRAW, on span done:
  - Outline interior row with left edge just drawn and x_hi != x_lo: go to RIGHT_START (span x_hi..x_hi), then back to SPAN_DRAW.
  - Otherwise, if row == y_end: go to FIN.
  - Otherwise: row <= row + 1 and go to SPAN_START.
- Interior row: row != min and row != max of the latched y range.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Output signals:
  - valid = span-engine valid (state SPAN_DRAW and oe).
  - x comes from the span engine; y = row.
- Comparisons use equality against the sorted end, so there is no overflow at the extremes of the signed range.
  - Degenerate cases (x0==x1 and/or y0==y1) produce exactly one pixel per distinct coordinate.
- start while busy: ignored; latched corners unchanged.
- oe low: x/y/row frozen, valid=0, no pixels lost or duplicated.
- rst mid-rectangle: next cycle state=IDLE, busy=0, done=0, valid=0; the span engine resets with it.

## Timing
- Reset values:
  - busy=0, done=0, valid=0, state=IDLE.
  - y=0.
  - x is don't-care while valid=0; it has no reset requirement.
- With oe held high and start at cycle 0:
  - SPAN_START at cycle 1.
  - First pixel valid at cycle 2.
- Per row of width W: W consecutive valid cycles, then 2 dead cycles before the next row (span done cycle plus SPAN_START).
  - Outline: the same 2-cycle gap applies between the left and right pixels.
- Last pixel at cycle T: done=1 and busy=0 at cycle T+2.
- A new start is accepted in the cycle after done, at the earliest.
- done and valid are never high together.

## Configuration
- FRECT_OUTLINE_EN defined:
  - The outline port exists.
  - outline=1 draws the first and last rows in full, and only x_lo and x_hi on interior rows.
  - RIGHT_START state is present.
- Not defined:
  - The outline port is absent and RIGHT_START is removed.
  - The block always fills.

## Structure
- State encodings are localparams inside frect.
- The CORDW default and the shared handshake conventions live in the common graphics constants package (gfx_pkg), used by all shape generators.
- One sub-module: fline, the horizontal span engine (x-run generator with start/oe/valid/busy/done).
  - frect instantiates it once, feeds its rst from frect rst, and gates its oe directly from frect oe.

## Test plan
- Fill: x0=5, x1=3, y0=3, y1=2, oe=1, start at cycle 0.
  - Pixels (3,2)(4,2)(5,2) at cycles 2–4.
  - Pixels (3,3)(4,3)(5,3) at cycles 7–9.
  - done=1 at cycle 11; exactly 6 valid cycles.
- Degenerate: x0=x1=7, y0=y1=-4.
  - Single pixel (7,-4) at cycle 2; done at cycle 4.
- Stall: same as the first fill, with oe low at cycles 3–5.
  - Same 6 pixels in the same order; valid=0 while oe low.
  - done is delayed by exactly 3 cycles.
- Outline (FRECT_OUTLINE_EN): x 0..3, y 0..2, outline=1.
  - Pixels (0,0)..(3,0), (0,1), (3,1), (0,2)..(3,2); 10 pixels total.
- Reset mid-rectangle: rst at the 3rd pixel of the first fill.
  - Next cycle busy=0, valid=0, done never pulses.
  - A following start of 1×1 at (0,0) yields pixel (0,0) normally.
- start asserted while busy: corners changed at cycle 4 of the first fill.
  - Output unchanged; exactly one done pulse.

Source files
------------

// File: rtl/gfx_pkg.sv
// Common graphics constants shared by the shape generators.
// Every generator uses the same start/oe/valid/busy/done handshake.
// start is sampled only when the generator is idle.
// oe low freezes the output position and forces valid low.
// busy is high while a shape is in progress.
// done pulses for one cycle after the last pixel and is never high together with valid.
package gfx_pkg;

  // Default signed coordinate width in bits.
  localparam int unsigned CordwDefault = 16;

  // States of the horizontal span engine (fline).
  typedef enum logic [1:0] {
    SpIdle,
    SpDraw,
    SpDone
  } span_state_e;

endpackage

// File: rtl/frect_if.sv
// Handshake and coordinate bundle for the filled-rectangle sequencer.
// master: the command decoder side; it drives start/oe/corners and observes the pixel stream.
// slave : the frect side.
// The outline signal exists only when FRECT_OUTLINE_EN is defined.
interface frect_if #(
  parameter int unsigned CORDW = gfx_pkg::CordwDefault
);
  logic                    start;
  logic                    oe;
  logic signed [CORDW-1:0] x0;
  logic signed [CORDW-1:0] y0;
  logic signed [CORDW-1:0] x1;
  logic signed [CORDW-1:0] y1;
`ifdef FRECT_OUTLINE_EN
  logic                    outline;
`endif
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic                    valid;
  logic                    busy;
  logic                    done;

`ifdef FRECT_OUTLINE_EN
  modport master (
    output start, oe, x0, y0, x1, y1, outline,
    input  x, y, valid, busy, done
  );
  modport slave (
    input  start, oe, x0, y0, x1, y1, outline,
    output x, y, valid, busy, done
  );
`else
  modport master (
    output start, oe, x0, y0, x1, y1,
    input  x, y, valid, busy, done
  );
  modport slave (
    input  start, oe, x0, y0, x1, y1,
    output x, y, valid, busy, done
  );
`endif

endinterface

// File: rtl/frect_fline.sv
// fline: horizontal span engine. It emits x = x0_i .. x1_i, one position per cycle while oe_i is high.
// The caller guarantees that x0_i <= x1_i.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start_i           latch x0_i/x1_i and begin; sampled only when idle
//   oe_i              output enable; low stalls the run
//   x0_i, x1_i        span endpoints (signed)
//   x_o               current x position
//   valid_o           x_o is valid this cycle
//   busy_o            span in progress (including the done cycle)
//   done_o            one-cycle pulse after the last position
module fline
  import gfx_pkg::*;
#(
  parameter int unsigned CORDW = CordwDefault
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    oe_i,
  input  logic signed [CORDW-1:0] x0_i,
  input  logic signed [CORDW-1:0] x1_i,
  output logic signed [CORDW-1:0] x_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    done_o
);

  span_state_e             state_q, state_d;
  logic signed [CORDW-1:0] x_q, x_d;
  logic signed [CORDW-1:0] x_end_q, x_end_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SpIdle;
      x_q     <= '0;
      x_end_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x_end_q <= x_end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x_end_d = x_end_q;
    valid_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      SpIdle: begin
        if (start_i) begin
          x_d     = x0_i;
          x_end_d = x1_i;
          state_d = SpDraw;
        end
      end
      SpDraw: begin
        valid_o = oe_i;
        if (oe_i) begin
          // The end test is an equality check, so x never increments past the top of the signed range.
          if (x_q == x_end_q) begin
            state_d = SpDone;
          end else begin
            x_d = x_q + CORDW'(1);
          end
        end
      end
      SpDone: begin
        done_o  = 1'b1;
        state_d = SpIdle;
      end
      default: state_d = SpIdle;
    endcase
  end

  assign x_o    = x_q;
  assign busy_o = (state_q != SpIdle);

endmodule

// File: rtl/frect.sv
// frect: filled-rectangle sequencer. It walks the rectangle row by row.
// For each row it starts one fline span and emits one pixel per enabled cycle.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        frect_if.slave
//              inputs : start, oe, x0/y0/x1/y1 corners, outline (with FRECT_OUTLINE_EN)
//              outputs: x, y, valid, busy, done
// Build option FRECT_OUTLINE_EN: adds the outline input and the RIGHT_START state.
// With outline set, interior rows draw only x_lo and x_hi.
module frect
  import gfx_pkg::*;
#(
  parameter int unsigned CORDW = CordwDefault
) (
  input logic    clk,
  input logic    rst,
  frect_if.slave bus
);

`ifdef FRECT_OUTLINE_EN
  typedef enum logic [2:0] {
    StIdle,
    StSpanStart,
    StSpanDraw,
    StRightStart,
    StFin
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle,
    StSpanStart,
    StSpanDraw,
    StFin
  } state_e;
`endif

  state_e                  state_q, state_d;
  logic signed [CORDW-1:0] x_lo_q, x_lo_d;
  logic signed [CORDW-1:0] x_hi_q, x_hi_d;
  logic signed [CORDW-1:0] row_q, row_d;
  logic signed [CORDW-1:0] y_end_q, y_end_d;
`ifdef FRECT_OUTLINE_EN
  logic signed [CORDW-1:0] y_lo_q, y_lo_d;
  logic                    outline_q, outline_d;
  logic                    right_q, right_d;   // right-edge pixel of this row already started
  logic                    interior;
`endif

  logic                    span_start;
  logic signed [CORDW-1:0] span_x0, span_x1, span_x;
  logic                    span_valid, span_busy, span_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      x_lo_q    <= '0;
      x_hi_q    <= '0;
      row_q     <= '0;
      y_end_q   <= '0;
`ifdef FRECT_OUTLINE_EN
      y_lo_q    <= '0;
      outline_q <= 1'b0;
      right_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_lo_q    <= x_lo_d;
      x_hi_q    <= x_hi_d;
      row_q     <= row_d;
      y_end_q   <= y_end_d;
`ifdef FRECT_OUTLINE_EN
      y_lo_q    <= y_lo_d;
      outline_q <= outline_d;
      right_q   <= right_d;
`endif
    end
  end

`ifdef FRECT_OUTLINE_EN
  assign interior = (row_q != y_lo_q) && (row_q != y_end_q);
`endif

  always_comb begin
    state_d    = state_q;
    x_lo_d     = x_lo_q;
    x_hi_d     = x_hi_q;
    row_d      = row_q;
    y_end_d    = y_end_q;
`ifdef FRECT_OUTLINE_EN
    y_lo_d     = y_lo_q;
    outline_d  = outline_q;
    right_d    = right_q;
`endif
    span_start = 1'b0;
    span_x0    = x_lo_q;
    span_x1    = x_hi_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_lo_d  = (bus.x0 < bus.x1) ? bus.x0 : bus.x1;
          x_hi_d  = (bus.x0 < bus.x1) ? bus.x1 : bus.x0;
          row_d   = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
          y_end_d = (bus.y0 < bus.y1) ? bus.y1 : bus.y0;
`ifdef FRECT_OUTLINE_EN
          y_lo_d    = (bus.y0 < bus.y1) ? bus.y0 : bus.y1;
          outline_d = bus.outline;
`endif
          state_d = StSpanStart;
        end
      end
      StSpanStart: begin
        span_start = 1'b1;
`ifdef FRECT_OUTLINE_EN
        right_d = 1'b0;
        // The left edge is the only pixel of the first span on an outline interior row.
        if (outline_q && interior) span_x1 = x_lo_q;
`endif
        state_d = StSpanDraw;
      end
      StSpanDraw: begin
        if (span_done) begin
`ifdef FRECT_OUTLINE_EN
          if (outline_q && interior && !right_q && (x_hi_q != x_lo_q)) begin
            state_d = StRightStart;
          end else
`endif
          if (row_q == y_end_q) begin
            state_d = StFin;
          end else begin
            row_d   = row_q + CORDW'(1);
            state_d = StSpanStart;
          end
        end
      end
`ifdef FRECT_OUTLINE_EN
      StRightStart: begin
        span_start = 1'b1;
        span_x0    = x_hi_q;
        right_d    = 1'b1;
        state_d    = StSpanDraw;
      end
`endif
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  fline #(
    .CORDW (CORDW)
  ) u_fline (
    .clk     (clk),
    .rst     (rst),
    .start_i (span_start),
    .oe_i    (bus.oe),
    .x0_i    (span_x0),
    .x1_i    (span_x1),
    .x_o     (span_x),
    .valid_o (span_valid),
    .busy_o  (span_busy),
    .done_o  (span_done)
  );

  assign bus.x     = span_x;
  assign bus.y     = row_q;
  assign bus.valid = span_valid;
  assign bus.done  = (state_q == StFin);
  // The span is only ever busy inside a sequencer-busy state; OR-ing it in keeps both views consistent.
  assign bus.busy  = ((state_q != StIdle) && (state_q != StFin)) || span_busy;

endmodule
